mskand_hpc_pipe: RTL and testbench
==================================

Name: mskand_hpc_pipe

Overview:
- Multi-lane, d-share masked AND gadget of HPC type: refresh of operand b, then DOM-style cross-product multiplication, fully registered.
- Carries a valid token through the pipeline and has an asynchronous reset.
- Supplies randomness either aligned with the inputs or one cycle late.
- Used as the standard AND building block in masked S-box datapaths where several independent ANDs are issued per cycle.

Parameters:
- d, 2, number of shares per bit; legal d >= 2.
- N, 1, number of independent AND lanes; legal N >= 1.
- RND_LAT, 0, mul-randomness timing. 0: presented with in_valid and delayed one cycle internally. 1: presented one cycle after in_valid.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  ina/inb/refresh randomness valid this cycle
- ina  input  N*d  operand a; lane k, share i at bit k*d+i
- inb  input  N*d  operand b, same layout
- rnd  input  N*NRND  lane k occupies bits [k*NRND +: NRND]; low REF_NRND bits are refresh randomness, upper MUL_NRND bits are mul randomness
- out  output  N*d  masked a&b, same layout
- out_valid  output  1  out holds a new result

Behaviour:
- Widths per lane:
  - REF_NRND = d-1
  - MUL_NRND = d*(d-1)/2
  - NRND = REF_NRND + MUL_NRND
- Reset (rst_n=0, asynchronous): all valid flags, data registers and the rnd delay register clear to 0. out=0, out_valid=0 while rst_n low and until the first valid result.
- Stage 1 (loads when in_valid=1, else holds):
  - a1 = ina.
  - b1 refresh: b1[j] = inb[j]^r[j] for j<d-1; b1[d-1] = inb[d-1] ^ XOR of all r[0..d-2].
  - v1 <= in_valid.
- Mul randomness:
  - RND_LAT=0: the mul field is captured with stage 1 into rnd_d and consumed from rnd_d.
  - RND_LAT=1: the mul field is taken directly from rnd in the cycle stage 2 loads. It is ignored in the cycle in_valid is high.
  - Refresh randomness is always consumed with in_valid.
- Stage 2 (loads when v1=1, else holds): c[i][j] registered per lane.
  - c[i][i] = a1[i]&b1[i]
  - for i<j: c[i][j] = a1[i]&b1[j] ^ r_ij
  - for i>j: c[i][j] = a1[i]&b1[j] ^ r_ji
  - r_ij indexed row-major over pairs i<j: (0,1),(0,2)..(1,2)...
  - v2 <= v1.
- Stage 3 (loads when v2=1, else holds): out[i] = XOR over j of c[i][j]; out_valid <= v2.
- Latency: in_valid in cycle t gives out_valid=1 in cycle t+3, exactly one cycle wide per accepted input.
- Throughput: one input per cycle; back-to-back inputs produce back-to-back outputs. No backpressure.
- Gaps: when out_valid=0 after a result, out holds the last result unchanged.
- Correctness invariant per lane: XOR(out shares) = XOR(ina shares) & XOR(inb shares).
- Lanes are fully independent; no randomness is shared across lanes.
- Reset mid-operation: in-flight tokens are dropped; no out_valid is produced for inputs accepted before reset.
- Security requirements:
  - Every cross product is registered before compression.
  - No share pair is combined before a register.
  - Refreshed b is registered before multiplication.

Decomposition:
- Package mskand_hpc_pkg holds:
  - functions ref_nrnd(d), mul_nrnd(d), nrnd(d);
  - function pair_idx(i,j,d) for the r_ij index.
- Sub-module mskand_hpc_lane holds one lane's stage 1–3 data path, the rnd delay and the c matrix.
- The top holds the shared v1/v2/out_valid chain and instantiates the N lanes.
- Each lane receives the shared valid enables.

Test Plan:
- d=2, N=1, RND_LAT=0: in_valid=1 at t0 with ina=2'b10, inb=2'b01, rnd=2'b00 → out=2'b10, out_valid=1 at t3 only.
- Same inputs with rnd=2'b11 → out shares differ from previous run, XOR(out)=1. Also a=0,b=1 → XOR(out)=0.
- d=3, N=4, both RND_LAT values: 1000 random back-to-back inputs with random rnd (aligned per RND_LAT) → every cycle from t3, XOR(out) per lane equals a&b; out_valid continuous.
- Valid gaps (pattern 1,0,0,1): out_valid=1 at t3 and t6 only. out unchanged during t4–t5.
- rst_n pulsed low asynchronously mid-cycle at t1 after in_valid at t0 → out=0 and out_valid=0 immediately. No out_valid at t3; the next input after release yields its result 3 cycles later.
- RND_LAT=1: mul randomness driven as garbage at t0 and correct at t1 → result correct. Sharing-independence check: with fixed inputs and random rnd, each out share is uniformly distributed over the run.

Source files
------------

// File: rtl/mskand_hpc_pkg.sv
// Shared widths and randomness indexing for the HPC masked AND pipeline.
package mskand_hpc_pkg;

  function automatic int unsigned ref_nrnd(input int unsigned d);
    return d - 1;
  endfunction

  function automatic int unsigned mul_nrnd(input int unsigned d);
    return (d * (d - 1)) / 2;
  endfunction

  function automatic int unsigned nrnd(input int unsigned d);
    return ref_nrnd(d) + mul_nrnd(d);
  endfunction

  // Row-major index of pair (i,j), i<j: (0,1),(0,2)..(1,2)..
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned d);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/mskand_hpc_pipe_if.sv
// Data/valid bundle of the masked AND pipeline; master drives operands, slave returns results.
interface mskand_hpc_pipe_if
  import mskand_hpc_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned N = 1
);
  localparam int unsigned RndN = nrnd(d);

  logic              in_valid;
  logic [N*d-1:0]    ina;
  logic [N*d-1:0]    inb;
  logic [N*RndN-1:0] rnd;
  logic [N*d-1:0]    out;
  logic              out_valid;

  modport master (output in_valid, ina, inb, rnd, input out, out_valid);
  modport slave  (input in_valid, ina, inb, rnd, output out, out_valid);
endinterface

// File: rtl/mskand_hpc_lane.sv
// One lane of the HPC masked AND: refresh of b, registered cross products, share compression.
module mskand_hpc_lane
  import mskand_hpc_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned RND_LAT = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ld1_i,
  input  logic                ld2_i,
  input  logic                ld3_i,
  input  logic [d-1:0]        ina_i,
  input  logic [d-1:0]        inb_i,
  input  logic [nrnd(d)-1:0]  rnd_i,
  output logic [d-1:0]        out_o
);
  localparam int unsigned RefN = ref_nrnd(d);
  localparam int unsigned MulN = mul_nrnd(d);
  localparam int unsigned RndN = nrnd(d);

  logic [RefN-1:0]  rref;
  logic [MulN-1:0]  rmul_in, rmul;
  logic [d-1:0]     a1_q, b1_q, b1_d;
  logic [d*d-1:0]   c_q, c_d;
  logic [d-1:0]     out_q, out_d;

  assign rref    = rnd_i[RefN-1:0];
  assign rmul_in = rnd_i[RndN-1:RefN];

  always_comb begin : refresh_b
    logic rx;
    rx   = 1'b0;
    b1_d = inb_i;
    for (int unsigned j = 0; j < d - 1; j++) begin
      b1_d[j] = inb_i[j] ^ rref[j];
      rx      = rx ^ rref[j];
    end
    b1_d[d-1] = inb_i[d-1] ^ rx;
  end

  if (RND_LAT == 0) begin : g_rnd_dly
    logic [MulN-1:0] rmul_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rmul_q <= '0;
      end else if (ld1_i) begin
        rmul_q <= rmul_in;
      end
    end
    assign rmul = rmul_q;
  end else begin : g_rnd_direct
    assign rmul = rmul_in;
  end

  // Off-diagonal terms share one mask per pair so it cancels in the output XOR.
  always_comb begin : cross_products
    logic p;
    c_d = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        p = a1_q[i] & b1_q[j];
        if (i < j) begin
          p = p ^ rmul[pair_idx(i, j, d)];
        end else if (i > j) begin
          p = p ^ rmul[pair_idx(j, i, d)];
        end
        c_d[i*d+j] = p;
      end
    end
  end

  always_comb begin : compress
    logic x;
    out_d = '0;
    for (int unsigned i = 0; i < d; i++) begin
      x = 1'b0;
      for (int unsigned j = 0; j < d; j++) begin
        x = x ^ c_q[i*d+j];
      end
      out_d[i] = x;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a1_q <= '0;
      b1_q <= '0;
    end else if (ld1_i) begin
      a1_q <= ina_i;
      b1_q <= b1_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q <= '0;
    end else if (ld2_i) begin
      c_q <= c_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (ld3_i) begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/mskand_hpc_pipe.sv
// Multi-lane d-share HPC masked AND; three register stages with a shared valid chain.
module mskand_hpc_pipe
  import mskand_hpc_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned N       = 1,
  parameter int unsigned RND_LAT = 0
) (
  input logic              clk,
  input logic              rst_n,
  mskand_hpc_pipe_if.slave bus
);
  localparam int unsigned RndN = nrnd(d);

  logic           v1_q, v2_q, out_valid_q;
  logic [N*d-1:0] out_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= bus.in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    mskand_hpc_lane #(
      .d       (d),
      .RND_LAT (RND_LAT)
    ) u_lane (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .ld1_i  (bus.in_valid),
      .ld2_i  (v1_q),
      .ld3_i  (v2_q),
      .ina_i  (bus.ina[k*d +: d]),
      .inb_i  (bus.inb[k*d +: d]),
      .rnd_i  (bus.rnd[k*RndN +: RndN]),
      .out_o  (out_w[k*d +: d])
    );
  end

  assign bus.out       = out_w;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mskand_hpc_pipe.sv
// Bench for mskand_hpc_pipe: d=2 directed vectors plus d=3,N=4 streams for both rnd timings.
module tb_mskand_hpc_pipe;

  localparam int MaxLen = 1100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mskand_hpc_pipe_if #(.d(2), .N(1)) if2 ();
  mskand_hpc_pipe_if #(.d(3), .N(4)) if30 ();
  mskand_hpc_pipe_if #(.d(3), .N(4)) if31 ();

  mskand_hpc_pipe #(.d(2), .N(1), .RND_LAT(0)) u_d2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  mskand_hpc_pipe #(.d(3), .N(4), .RND_LAT(0)) u_rl0 (.clk(clk), .rst_n(rst_n), .bus(if30));
  mskand_hpc_pipe #(.d(3), .N(4), .RND_LAT(1)) u_rl1 (.clk(clk), .rst_n(rst_n), .bus(if31));

  int n_tests = 0;
  int n_fail  = 0;

  logic        sv_val [MaxLen];
  logic [11:0] sv_a   [MaxLen];
  logic [11:0] sv_b   [MaxLen];
  logic [19:0] sv_r   [MaxLen];
  logic [11:0] last0, last1;
  int          ones   [12];
  bit          cnt_en;

  // Reference for one 3-share lane straight from the gadget's algebraic definition.
  function automatic logic [2:0] and3(input logic [2:0] a, input logic [2:0] b,
                                      input logic [1:0] rf, input logic [2:0] rm);
    logic [2:0] bb, o;
    int idx [3][3];
    int p;
    bb = b ^ {rf[0] ^ rf[1], rf[1], rf[0]};
    p = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 3; j++) begin
        idx[i][j] = p;
        idx[j][i] = p;
        p++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      o[i] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        o[i] = o[i] ^ (a[i] & bb[j]);
        if (i != j) o[i] = o[i] ^ rm[idx[i][j]];
      end
    end
    return o;
  endfunction

  // Expected out vector for the input issued at index k; late mode takes mul bits one entry later.
  function automatic logic [11:0] exp_out(input int k, input bit late);
    logic [11:0] r;
    logic [19:0] rm;
    rm = late ? sv_r[k+1] : sv_r[k];
    for (int l = 0; l < 4; l++) begin
      r[3*l +: 3] = and3(sv_a[k][3*l +: 3], sv_b[k][3*l +: 3], sv_r[k][5*l +: 2],
                         rm[5*l+2 +: 3]);
    end
    return r;
  endfunction

  task automatic drive_idle();
    if2.in_valid  = 1'b0; if2.ina  = '0; if2.inb  = '0; if2.rnd  = '0;
    if30.in_valid = 1'b0; if30.ina = '0; if30.inb = '0; if30.rnd = '0;
    if31.in_valid = 1'b0; if31.ina = '0; if31.inb = '0; if31.rnd = '0;
  endtask

  // Plays sv_* for n cycles plus drain, checking both d=3 instances every cycle.
  task automatic run3(input int n);
    logic        ev;
    logic [11:0] a, b, o;
    for (int k = n; k < n + 5; k++) begin
      sv_val[k] = 1'b0; sv_a[k] = '0; sv_b[k] = '0; sv_r[k] = '0;
    end
    for (int k = 0; k < n + 4; k++) begin
      @(posedge clk); #1;
      if30.in_valid = sv_val[k]; if30.ina = sv_a[k]; if30.inb = sv_b[k]; if30.rnd = sv_r[k];
      if31.in_valid = sv_val[k]; if31.ina = sv_a[k]; if31.inb = sv_b[k]; if31.rnd = sv_r[k];
      @(negedge clk);
      ev = (k >= 3) ? sv_val[k-3] : 1'b0;
      if (ev) begin
        last0 = exp_out(k - 3, 1'b0);
        last1 = exp_out(k - 3, 1'b1);
      end
      n_tests += 4;
      if (if30.out_valid !== ev) begin
        n_fail++; $display("FAIL rl0_valid cyc %0d: got %b expected %b", k, if30.out_valid, ev);
      end
      if (if31.out_valid !== ev) begin
        n_fail++; $display("FAIL rl1_valid cyc %0d: got %b expected %b", k, if31.out_valid, ev);
      end
      if (if30.out !== last0) begin
        n_fail++; $display("FAIL rl0_out cyc %0d: got %h expected %h", k, if30.out, last0);
      end
      if (if31.out !== last1) begin
        n_fail++; $display("FAIL rl1_out cyc %0d: got %h expected %h", k, if31.out, last1);
      end
      if (ev) begin
        a = sv_a[k-3]; b = sv_b[k-3];
        for (int l = 0; l < 4; l++) begin
          n_tests++;
          o = if30.out;
          if ((^o[3*l +: 3]) !== ((^a[3*l +: 3]) & (^b[3*l +: 3]))) begin
            n_fail++;
            $display("FAIL parity lane %0d cyc %0d: got %b expected %b", l, k, ^o[3*l +: 3],
                     (^a[3*l +: 3]) & (^b[3*l +: 3]));
          end
          if (cnt_en) for (int i = 0; i < 3; i++) ones[3*l+i] += int'(o[3*l+i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    last0 = '0; last1 = '0; cnt_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests += 3;
    if (if2.out !== 2'b00 || if2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_d2: got %b/%b expected 00/0", if2.out, if2.out_valid);
    end
    if (if30.out !== '0 || if30.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rl0: got %h/%b expected 0/0", if30.out, if30.out_valid);
    end
    if (if31.out !== '0 || if31.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rl1: got %h/%b expected 0/0", if31.out, if31.out_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (if2.out !== 2'b00 || if2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_d2: got %b/%b expected 00/0", if2.out, if2.out_valid);
    end
  endtask

  // Single d=2 transaction; out_valid must pulse only in cycle 3 and out must hold afterwards.
  task automatic d2_txn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] r,
                        input logic [1:0] exp, input logic exp_par);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if2.in_valid = (c == 0);
      if2.ina = (c == 0) ? a : 2'($urandom);
      if2.inb = (c == 0) ? b : 2'($urandom);
      if2.rnd = (c == 0) ? r : 2'($urandom);
      @(negedge clk);
      n_tests++;
      if (if2.out_valid !== (c == 3)) begin
        n_fail++; $display("FAIL d2_valid cyc %0d: got %b expected %b", c, if2.out_valid, c == 3);
      end
      if (c >= 3) begin
        n_tests += 2;
        if (if2.out !== exp) begin
          n_fail++; $display("FAIL d2_out cyc %0d: got %b expected %b", c, if2.out, exp);
        end
        if ((^if2.out) !== exp_par) begin
          n_fail++; $display("FAIL d2_parity cyc %0d: got %b expected %b", c, ^if2.out, exp_par);
        end
      end
    end
    if2.in_valid = 1'b0;
  endtask

  task automatic test_d2_basic();
    d2_txn(2'b10, 2'b01, 2'b00, 2'b10, 1'b1);
    d2_txn(2'b10, 2'b01, 2'b11, 2'b01, 1'b1);
    d2_txn(2'b00, 2'b01, 2'b10, 2'b11, 1'b0);
  endtask

  task automatic test_reset_mid();
    d2_txn(2'b10, 2'b01, 2'b00, 2'b10, 1'b1);
    @(posedge clk); #1;
    if2.in_valid = 1'b1; if2.ina = 2'b11; if2.inb = 2'b10; if2.rnd = 2'b01;
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (if2.out !== 2'b00) begin
      n_fail++; $display("FAIL midreset_out: got %b expected 00", if2.out);
    end
    if (if2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid: got %b expected 0", if2.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last0 = '0; last1 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (if2.out_valid !== 1'b0 || if2.out !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_drop cyc %0d: got %b/%b expected 00/0", c, if2.out, if2.out_valid);
      end
    end
    d2_txn(2'b10, 2'b01, 2'b00, 2'b10, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 1000; k++) begin
      sv_val[k] = 1'b1; sv_a[k] = 12'($urandom); sv_b[k] = 12'($urandom);
      sv_r[k] = 20'($urandom);
    end
    run3(1000);
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 4; k++) begin
      sv_val[k] = (k == 0 || k == 3); sv_a[k] = 12'($urandom); sv_b[k] = 12'($urandom);
      sv_r[k] = 20'($urandom);
    end
    run3(4);
  endtask

  task automatic test_rnd_late();
    sv_val[0] = 1'b1; sv_a[0] = 12'hfff; sv_b[0] = 12'hb6d; sv_r[0] = 20'hfffff;
    sv_val[1] = 1'b0; sv_a[1] = 12'($urandom); sv_b[1] = 12'($urandom); sv_r[1] = 20'h12345;
    sv_val[2] = 1'b1; sv_a[2] = 12'($urandom); sv_b[2] = 12'($urandom); sv_r[2] = 20'($urandom);
    sv_val[3] = 1'b1; sv_a[3] = 12'($urandom); sv_b[3] = 12'($urandom); sv_r[3] = 20'($urandom);
    run3(4);
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 12; i++) ones[i] = 0;
    for (int k = 0; k < 1000; k++) begin
      sv_val[k] = 1'b1; sv_a[k] = 12'h5a3; sv_b[k] = 12'h3c7; sv_r[k] = 20'($urandom);
    end
    cnt_en = 1'b1;
    run3(1000);
    cnt_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (ones[i] < 400 || ones[i] > 600) begin
        n_fail++; $display("FAIL uniform share %0d: got %0d ones expected 400..600", i, ones[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_d2_basic();
    test_reset_mid();
    test_back_to_back();
    test_gaps();
    test_rnd_late();
    test_uniform();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
